// File: rtl/alu8_sequencer_if.sv
// Request/result and nibble-ALU bus for the 8-bit ALU sequencer.
// The slave side is the sequencer; the master side is decode plus the nibble ALU.
interface alu8_sequencer_if;
    logic       req_valid;
    logic       req_ready;
    logic [2:0] req_op;
    logic [7:0] req_a;
    logic [7:0] req_b;
    logic       req_cin;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [2:0] alu_op;
    logic       alu_cin;
    logic [3:0] alu_out;
    logic       alu_z;
    logic       alu_c;
    logic       res_valid;
    logic [7:0] res_data;
    logic [3:0] res_flags;

    modport slave (
        input  req_valid, req_op, req_a, req_b, req_cin,
        input  alu_out, alu_z, alu_c,
        output req_ready, alu_a, alu_b, alu_op, alu_cin,
        output res_valid, res_data, res_flags
    );

    modport master (
        output req_valid, req_op, req_a, req_b, req_cin,
        output alu_out, alu_z, alu_c,
        input  req_ready, alu_a, alu_b, alu_op, alu_cin,
        input  res_valid, res_data, res_flags
    );
endinterface

// File: rtl/alu8_sequencer.sv
// Runs one 8-bit ALU op as two passes through a 4-bit nibble ALU,
// low nibble first, chaining the low carry/borrow into the high pass.
module alu8_sequencer (
    input  logic           clock,
    input  logic           reset,
    alu8_sequencer_if.slave bus
);
    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_ADC = 3'd1;
    localparam logic [2:0] OP_SUB = 3'd2;
    localparam logic [2:0] OP_SBC = 3'd3;
    localparam logic [2:0] OP_AND = 3'd4;
    localparam logic [2:0] OP_CP  = 3'd7;

    typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;

    state_t     state;
    logic [2:0] op_q;
    logic [7:0] a_q;
    logic [7:0] b_q;
    logic       cin_q;
    logic [3:0] lo_out;
    logic       lo_z;
    logic       lo_c;
    logic       res_valid_q;
    logic [7:0] res_data_q;
    logic [3:0] res_flags_q;

    logic       arith;
    logic       flag_z;
    logic       flag_n;
    logic       flag_h;
    logic       flag_c;

    assign bus.req_ready = (state == IDLE);
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_flags = res_flags_q;

    always_comb begin
        bus.alu_a   = 4'h0;
        bus.alu_b   = 4'h0;
        bus.alu_op  = 3'd0;
        bus.alu_cin = 1'b0;
        unique case (state)
            LOW: begin
                bus.alu_a   = a_q[3:0];
                bus.alu_b   = b_q[3:0];
                bus.alu_op  = op_q;
                bus.alu_cin = (op_q == OP_ADC || op_q == OP_SBC) ? cin_q : 1'b0;
            end
            HIGH: begin
                bus.alu_a   = a_q[7:4];
                bus.alu_b   = b_q[7:4];
                bus.alu_cin = lo_c;
                // Plain add/sub become their carry forms so the chain works.
                if (op_q == OP_ADD)
                    bus.alu_op = OP_ADC;
                else if (op_q == OP_SUB)
                    bus.alu_op = OP_SBC;
                else
                    bus.alu_op = op_q;
            end
            default: ;
        endcase
    end

    always_comb begin
        arith  = (op_q inside {OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_CP});
        flag_z = bus.alu_z & lo_z;
        flag_n = (op_q inside {OP_SUB, OP_SBC, OP_CP});
        flag_h = arith ? lo_c : (op_q == OP_AND);
        flag_c = arith ? bus.alu_c : 1'b0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            op_q        <= 3'd0;
            a_q         <= 8'h00;
            b_q         <= 8'h00;
            cin_q       <= 1'b0;
            lo_out      <= 4'h0;
            lo_z        <= 1'b0;
            lo_c        <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= 8'h00;
            res_flags_q <= 4'h0;
        end else begin
            res_valid_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        op_q  <= bus.req_op;
                        a_q   <= bus.req_a;
                        b_q   <= bus.req_b;
                        cin_q <= bus.req_cin;
                        state <= LOW;
                    end
                end
                LOW: begin
                    lo_out <= bus.alu_out;
                    lo_z   <= bus.alu_z;
                    lo_c   <= bus.alu_c;
                    state  <= HIGH;
                end
                HIGH: begin
                    res_valid_q <= 1'b1;
                    res_data_q  <= {bus.alu_out, lo_out};
                    res_flags_q <= {flag_z, flag_n, flag_h, flag_c};
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
